// File: rtl/cache_fill_arbiter_pkg.sv
// Shared types and block geometry for the cache fill arbiter.
package cache_mem_pkg;
  localparam int WORDS_PER_BLOCK = 8;
  localparam int BLOCK_OFFSET_W  = 4;
  localparam int MEM_LATENCY     = 4;
  localparam int CNT_W           = $clog2(WORDS_PER_BLOCK);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FILL  = 3'd1,
    DRAIN = 3'd2,
    DONE  = 3'd3,
    WRITE = 3'd4
  } arbState_t;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } requester_t;
endpackage

// File: rtl/cache_fill_arbiter_if.sv
// Bundle of cache request, memory and fill signals around the fill arbiter.
// master: the arbiter; slave: caches plus memory model.
interface cache_fill_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              i_miss;
  logic [ADDR_W-1:0] i_miss_addr;
  logic              d_miss;
  logic [ADDR_W-1:0] d_miss_addr;
  logic              d_wr;
  logic [ADDR_W-1:0] d_wr_addr;
  logic [DATA_W-1:0] d_wr_data;
  logic              mem_en;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_rvalid;
  logic              fill_we;
  logic              fill_sel;
  logic [ADDR_W-1:0] fill_addr;
  logic [DATA_W-1:0] fill_data;
  logic              i_fill_done;
  logic              d_fill_done;
  logic              d_wr_done;
  logic              busy;

  modport master (
    input  i_miss, i_miss_addr, d_miss, d_miss_addr, d_wr, d_wr_addr, d_wr_data,
           mem_rdata, mem_rvalid,
    output mem_en, mem_wr, mem_addr, mem_wdata, fill_we, fill_sel, fill_addr, fill_data,
           i_fill_done, d_fill_done, d_wr_done, busy
  );

  modport slave (
    output i_miss, i_miss_addr, d_miss, d_miss_addr, d_wr, d_wr_addr, d_wr_data,
           mem_rdata, mem_rvalid,
    input  mem_en, mem_wr, mem_addr, mem_wdata, fill_we, fill_sel, fill_addr, fill_data,
           i_fill_done, d_fill_done, d_wr_done, busy
  );
endinterface

// File: rtl/fill_addr_gen.sv
// Maps block base, start word offset and a word counter to a byte address inside the block.
module fill_addr_gen
  import cache_mem_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic [ADDR_W-1:0] base,
  input  logic [CNT_W-1:0]  startOff,
  input  logic [CNT_W-1:0]  cnt,
  output logic [ADDR_W-1:0] byteAddr
);
  logic [CNT_W-1:0] wordOff;

  // Offset wraps inside the block, so the add never carries past the block base.
  assign wordOff  = startOff + cnt;
  assign byteAddr = base + ADDR_W'({wordOff, 1'b0});
endmodule

// File: rtl/cache_fill_arbiter.sv
// Arbitrates I/D cache block fills and D-cache write-through stores onto one pipelined memory.
// Build option FILL_CRITICAL_WORD_FIRST_EN: issue and fill start at the missed word and wrap within the block.
module cache_fill_arbiter
  import cache_mem_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input logic                 clk,
  input logic                 rst_n,
  cache_fill_arbiter_if.master bus
);
  // state | meaning
  // IDLE  | waiting; grant priority d_miss > d_wr > i_miss
  // FILL  | issuing one block read per cycle, returns may already arrive
  // DRAIN | all reads issued, collecting the remaining returns
  // DONE  | one-cycle fill completion pulse to the requester
  // WRITE | single-cycle write-through store with d_wr_done

  localparam logic [ADDR_W-1:0] BLOCK_MASK = ~ADDR_W'((1 << BLOCK_OFFSET_W) - 1);
  localparam logic [CNT_W-1:0]  LAST_CNT   = CNT_W'(WORDS_PER_BLOCK - 1);

  arbState_t         state;
  arbState_t         stateNext;
  requester_t        req;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] issueAddr;
  logic [ADDR_W-1:0] retAddr;
  logic [CNT_W-1:0]  issueCnt;
  logic [CNT_W-1:0]  retCnt;
  logic [CNT_W-1:0]  startOff;
  logic              grantD;
  logic              grantI;
  logic              retire;

  assign grantD = (state == IDLE) && bus.d_miss;
  assign grantI = (state == IDLE) && !bus.d_miss && !bus.d_wr && bus.i_miss;
  // Returns outside FILL/DRAIN (e.g. in flight across a reset) are dropped here.
  assign retire = ((state == FILL) || (state == DRAIN)) && bus.mem_rvalid;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE: begin
        if (bus.d_miss)      stateNext = FILL;
        else if (bus.d_wr)   stateNext = WRITE;
        else if (bus.i_miss) stateNext = FILL;
      end
      FILL:    if (issueCnt == LAST_CNT) stateNext = DRAIN;
      DRAIN:   if (retire && (retCnt == LAST_CNT)) stateNext = DONE;
      DONE:    stateNext = IDLE;
      WRITE:   stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      issueCnt <= '0;
      retCnt   <= '0;
      base     <= '0;
      req      <= REQ_I;
    end else if (state == IDLE) begin
      issueCnt <= '0;
      retCnt   <= '0;
      if (grantD) begin
        req  <= REQ_D;
        base <= bus.d_miss_addr & BLOCK_MASK;
      end else if (grantI) begin
        req  <= REQ_I;
        base <= bus.i_miss_addr & BLOCK_MASK;
      end
    end else begin
      if (state == FILL) issueCnt <= issueCnt + CNT_W'(1);
      if (retire)        retCnt   <= retCnt + CNT_W'(1);
    end
  end

`ifdef FILL_CRITICAL_WORD_FIRST_EN
  always_ff @(posedge clk) begin
    if (!rst_n)      startOff <= '0;
    else if (grantD) startOff <= bus.d_miss_addr[BLOCK_OFFSET_W-1:1];
    else if (grantI) startOff <= bus.i_miss_addr[BLOCK_OFFSET_W-1:1];
  end
`else
  assign startOff = '0;
`endif

  fill_addr_gen #(.ADDR_W(ADDR_W)) uIssueAddr (
    .base     (base),
    .startOff (startOff),
    .cnt      (issueCnt),
    .byteAddr (issueAddr)
  );

  fill_addr_gen #(.ADDR_W(ADDR_W)) uRetAddr (
    .base     (base),
    .startOff (startOff),
    .cnt      (retCnt),
    .byteAddr (retAddr)
  );

  always_comb begin
    bus.mem_en      = 1'b0;
    bus.mem_wr      = 1'b0;
    bus.mem_addr    = '0;
    bus.mem_wdata   = '0;
    bus.fill_we     = 1'b0;
    bus.fill_sel    = 1'b0;
    bus.fill_addr   = '0;
    bus.fill_data   = '0;
    bus.i_fill_done = 1'b0;
    bus.d_fill_done = 1'b0;
    bus.d_wr_done   = 1'b0;
    bus.busy        = (state != IDLE);
    case (state)
      FILL: begin
        bus.mem_en   = 1'b1;
        bus.mem_addr = issueAddr;
      end
      WRITE: begin
        bus.mem_en    = 1'b1;
        bus.mem_wr    = 1'b1;
        bus.mem_addr  = bus.d_wr_addr;
        bus.mem_wdata = bus.d_wr_data;
        bus.d_wr_done = 1'b1;
      end
      DONE: begin
        if (req == REQ_D) bus.d_fill_done = 1'b1;
        else              bus.i_fill_done = 1'b1;
      end
      default: ;
    endcase
    if (retire) begin
      bus.fill_we   = 1'b1;
      bus.fill_sel  = (req == REQ_D);
      bus.fill_addr = retAddr;
      bus.fill_data = bus.mem_rdata;
    end
  end
endmodule

// File: tb/tb_cache_fill_arbiter.sv
// Bench for cache_fill_arbiter: vector table, multi-cycle corner sequences, and random
// traffic checked cycle by cycle against a transaction schedule model.
`timescale 1ns/1ps
module tb_cache_fill_arbiter;
  typedef struct packed {
    logic        en;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        fwe;
    logic        fsel;
    logic [15:0] faddr;
    logic [15:0] fdata;
    logic        idone;
    logic        ddone;
    logic        wdone;
    logic        busy;
  } outs_t;

  typedef struct {
    int          kind;        // 0 I miss, 1 D miss, 2 store
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] expFirst;
    logic [15:0] expLast;
    logic        expWr;
    int          expFirstFill;
    int          expFillCnt;
    logic        expSel;
    int          expDone;
  } vec_t;

`ifdef FILL_CRITICAL_WORD_FIRST_EN
  localparam bit CWF = 1'b1;
`else
  localparam bit CWF = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   nCmp  = 0;
  int   nBad  = 0;
  int   cyc   = 0;
  outs_t expv [int];

  always #5 clk = ~clk;

  cache_fill_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();
  cache_fill_arbiter #(.ADDR_W(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  // Memory model: every read returns a fixed function of its address four cycles after issue.
  logic [3:0]  pv = '0;
  logic [15:0] pa [4];
  always @(posedge clk) begin
    pv    <= {pv[2:0], bus.mem_en & ~bus.mem_wr};
    pa[0] <= bus.mem_addr;
    pa[1] <= pa[0];
    pa[2] <= pa[1];
    pa[3] <= pa[2];
  end
  assign bus.mem_rvalid = pv[3];
  assign bus.mem_rdata  = pv[3] ? memWord(pa[3]) : 16'h0;

  function automatic logic [15:0] memWord(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  function automatic logic [15:0] wordAddr(input logic [15:0] a, input int k);
    int start;
    start = CWF ? int'(a[3:1]) : 0;
    return (a & 16'hFFF0) + 16'(2 * ((start + k) % 8));
  endfunction

  function automatic outs_t sampleOuts();
    outs_t o;
    o.en = bus.mem_en;      o.wr = bus.mem_wr;     o.addr = bus.mem_addr;   o.wdata = bus.mem_wdata;
    o.fwe = bus.fill_we;    o.fsel = bus.fill_sel; o.faddr = bus.fill_addr; o.fdata = bus.fill_data;
    o.idone = bus.i_fill_done; o.ddone = bus.d_fill_done; o.wdone = bus.d_wr_done; o.busy = bus.busy;
    return o;
  endfunction

  function automatic outs_t getExp(input int c);
    outs_t e;
    e = '0;
    if (expv.exists(c)) e = expv[c];
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clearReqs();
    bus.i_miss = 1'b0; bus.i_miss_addr = '0;
    bus.d_miss = 1'b0; bus.d_miss_addr = '0;
    bus.d_wr   = 1'b0; bus.d_wr_addr   = '0; bus.d_wr_data = '0;
  endtask

  task automatic schedFill(input logic sel, input logic [15:0] a, input int t);
    outs_t e;
    for (int k = 0; k < 8; k++) begin
      e = getExp(t + 1 + k); e.en = 1'b1; e.addr = wordAddr(a, k); expv[t + 1 + k] = e;
      e = getExp(t + 5 + k); e.fwe = 1'b1; e.fsel = sel; e.faddr = wordAddr(a, k);
      e.fdata = memWord(wordAddr(a, k)); expv[t + 5 + k] = e;
    end
    for (int k = 1; k <= 13; k++) begin
      e = getExp(t + k); e.busy = 1'b1; expv[t + k] = e;
    end
    e = getExp(t + 13);
    if (sel) e.ddone = 1'b1; else e.idone = 1'b1;
    expv[t + 13] = e;
  endtask

  task automatic runOne(input vec_t v, input string tag);
    int t0, firstFill, fillCnt, doneAt;
    logic [15:0] firstA, lastA, firstW;
    logic gotEn, wrSeen, sel;
    logic [2:0] doneKind, expKind;
    t0 = cyc; firstFill = -1; fillCnt = 0; doneAt = -1;
    firstA = '0; lastA = '0; firstW = '0; gotEn = 1'b0; wrSeen = 1'b0; sel = 1'b0; doneKind = '0;
    expKind = (v.kind == 0) ? 3'b100 : (v.kind == 1) ? 3'b010 : 3'b001;
    case (v.kind)
      0:       begin bus.i_miss = 1'b1; bus.i_miss_addr = v.addr; end
      1:       begin bus.d_miss = 1'b1; bus.d_miss_addr = v.addr; end
      default: begin bus.d_wr = 1'b1; bus.d_wr_addr = v.addr; bus.d_wr_data = v.wdata; end
    endcase
    for (int k = 1; k <= 40 && doneAt < 0; k++) begin
      tick();
      if (bus.mem_en) begin
        if (!gotEn) begin gotEn = 1'b1; firstA = bus.mem_addr; firstW = bus.mem_wdata; end
        lastA  = bus.mem_addr;
        wrSeen = wrSeen | bus.mem_wr;
      end
      if (bus.fill_we) begin
        if (firstFill < 0) firstFill = cyc - t0;
        sel = sel | bus.fill_sel;
        check({tag, "_fill_addr"}, bus.fill_addr, wordAddr(v.addr, fillCnt));
        check({tag, "_fill_data"}, bus.fill_data, memWord(wordAddr(v.addr, fillCnt)));
        fillCnt++;
      end
      if (bus.i_fill_done || bus.d_fill_done || bus.d_wr_done) begin
        doneAt   = cyc - t0;
        doneKind = {bus.i_fill_done, bus.d_fill_done, bus.d_wr_done};
        clearReqs();
      end
    end
    tick();
    check({tag, "_busy_after"}, bus.busy, 1'b0);
    check({tag, "_first_addr"}, firstA, v.expFirst);
    check({tag, "_last_addr"}, lastA, v.expLast);
    check({tag, "_mem_wr"}, wrSeen, v.expWr);
    check({tag, "_mem_wdata"}, firstW, v.wdata);
    check({tag, "_first_fill_cyc"}, firstFill, v.expFirstFill);
    check({tag, "_fill_cnt"}, fillCnt, v.expFillCnt);
    check({tag, "_fill_sel"}, sel, v.expSel);
    check({tag, "_done_cyc"}, doneAt, v.expDone);
    check({tag, "_done_kind"}, doneKind, expKind);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [6];
    vec_t v;
    int t0, rel, iDone, dDone, wDone, wrCyc, wrCnt, weCnt, doneCnt, d1, d2, firstEn;
    int freeAt, iDoneAt, dDoneAt, wDoneAt;
    logic [15:0] a1, a15, wrA, wrD;

    vecs[0] = '{0, 16'h1236, 16'h0, CWF ? 16'h1236 : 16'h1230, CWF ? 16'h1234 : 16'h123E, 1'b0, 5, 8, 1'b0, 13};
    vecs[1] = '{1, 16'h8008, 16'h0, CWF ? 16'h8008 : 16'h8000, CWF ? 16'h8006 : 16'h800E, 1'b0, 5, 8, 1'b1, 13};
    vecs[2] = '{1, 16'h100A, 16'h0, CWF ? 16'h100A : 16'h1000, CWF ? 16'h1008 : 16'h100E, 1'b0, 5, 8, 1'b1, 13};
    vecs[3] = '{2, 16'h2002, 16'hBEEF, 16'h2002, 16'h2002, 1'b1, -1, 0, 1'b0, 1};
    vecs[4] = '{0, 16'hFFFE, 16'h0, CWF ? 16'hFFFE : 16'hFFF0, CWF ? 16'hFFFC : 16'hFFFE, 1'b0, 5, 8, 1'b0, 13};
    vecs[5] = '{0, 16'h0000, 16'h0, 16'h0000, 16'h000E, 1'b0, 5, 8, 1'b0, 13};

    clearReqs();
    rst_n = 1'b0;
    repeat (6) tick();
    check("reset_outputs", sampleOuts(), 96'h0);
    rst_n = 1'b1;
    tick();
    check("post_reset_idle", sampleOuts(), 96'h0);

    for (int i = 0; i < 6; i++) begin
      runOne(vecs[i], $sformatf("vec%0d", i));
      repeat (2) tick();
    end

    // Simultaneous I and D miss: D first, I regranted straight after.
    t0 = cyc; iDone = -1; dDone = -1; a1 = '0; a15 = '0;
    bus.i_miss = 1'b1; bus.i_miss_addr = 16'h0040;
    bus.d_miss = 1'b1; bus.d_miss_addr = 16'h8008;
    for (int k = 1; k <= 40 && iDone < 0; k++) begin
      tick();
      rel = cyc - t0;
      if (rel == 1)  a1  = bus.mem_addr;
      if (rel == 15) a15 = bus.mem_addr;
      if (bus.d_fill_done) begin dDone = rel; bus.d_miss = 1'b0; end
      if (bus.i_fill_done) begin iDone = rel; bus.i_miss = 1'b0; end
    end
    tick();
    check("simul_d_done", dDone, 13);
    check("simul_i_done", iDone, 27);
    check("simul_d_first", a1, CWF ? 16'h8008 : 16'h8000);
    check("simul_i_first", a15, 16'h0040);

    // Store arriving during an I fill waits for the fill to finish.
    repeat (2) tick();
    t0 = cyc; iDone = -1; wDone = -1; wrCyc = -1; wrCnt = 0; wrA = '0; wrD = '0;
    bus.i_miss = 1'b1; bus.i_miss_addr = 16'h1236;
    for (int k = 1; k <= 40 && wDone < 0; k++) begin
      tick();
      rel = cyc - t0;
      if (rel == 3) begin bus.d_wr = 1'b1; bus.d_wr_addr = 16'h2002; bus.d_wr_data = 16'hBEEF; end
      if (bus.mem_en && bus.mem_wr) begin
        wrCnt++;
        if (wrCyc < 0) begin wrCyc = rel; wrA = bus.mem_addr; wrD = bus.mem_wdata; end
      end
      if (bus.i_fill_done) begin iDone = rel; bus.i_miss = 1'b0; end
      if (bus.d_wr_done) begin wDone = rel; bus.d_wr = 1'b0; end
    end
    tick();
    check("store_wait_i_done", iDone, 13);
    check("store_wait_wr_cyc", wrCyc, 15);
    check("store_wait_done_cyc", wDone, 15);
    check("store_wait_addr", wrA, 16'h2002);
    check("store_wait_data", wrD, 16'hBEEF);
    check("store_wait_wr_cnt", wrCnt, 1);

    // Reset in the middle of a fill.
    repeat (2) tick();
    t0 = cyc;
    bus.i_miss = 1'b1; bus.i_miss_addr = 16'h0100;
    repeat (6) tick();
    rst_n = 1'b0;
    bus.i_miss = 1'b0;
    tick();
    check("rst_mid_outputs", sampleOuts(), 96'h0);
    rst_n = 1'b1;
    weCnt = 0; doneCnt = 0;
    for (int k = 0; k < 8; k++) begin
      if (bus.fill_we) weCnt++;
      if (bus.i_fill_done || bus.d_fill_done || bus.d_wr_done) doneCnt++;
      tick();
    end
    check("rst_mid_fill_we", weCnt, 0);
    check("rst_mid_done", doneCnt, 0);
    v = '{0, 16'h0200, 16'h0, 16'h0200, 16'h020E, 1'b0, 5, 8, 1'b0, 13};
    runOne(v, "post_rst");

    // Back-to-back I misses: request low at t14, raised again at t15.
    repeat (2) tick();
    t0 = cyc; d1 = -1; d2 = -1; firstEn = -1; weCnt = 0;
    bus.i_miss = 1'b1; bus.i_miss_addr = 16'h0300;
    for (int k = 1; k <= 45 && d2 < 0; k++) begin
      tick();
      rel = cyc - t0;
      if (bus.fill_we) weCnt++;
      if (bus.mem_en && d1 >= 0 && firstEn < 0) firstEn = rel;
      if (bus.i_fill_done) begin
        if (d1 < 0) d1 = rel; else d2 = rel;
        bus.i_miss = 1'b0;
      end
      if (rel == 15) begin bus.i_miss = 1'b1; bus.i_miss_addr = 16'h0300; end
    end
    tick();
    check("b2b_first_done", d1, 13);
    check("b2b_regrant_issue", firstEn, 16);
    check("b2b_second_done", d2, 28);
    check("b2b_fill_we_cnt", weCnt, 16);

    // Random traffic against the schedule model.
    repeat (4) tick();
    clearReqs();
    expv.delete();
    freeAt = 0; iDoneAt = -1; dDoneAt = -1; wDoneAt = -1;
    for (int n = 0; n < 3000; n++) begin
      tick();
      check("rand_cycle", sampleOuts(), getExp(cyc));
      if (expv.exists(cyc)) expv.delete(cyc);
      if (cyc == iDoneAt) bus.i_miss = 1'b0;
      if (cyc == dDoneAt) bus.d_miss = 1'b0;
      if (cyc == wDoneAt) bus.d_wr   = 1'b0;
      if (n < 2950) begin
        if (!bus.i_miss && cyc > iDoneAt && $urandom_range(0, 7) == 0) begin
          bus.i_miss = 1'b1; bus.i_miss_addr = 16'($urandom);
        end
        if (!bus.d_miss && cyc > dDoneAt && $urandom_range(0, 9) == 0) begin
          bus.d_miss = 1'b1; bus.d_miss_addr = 16'($urandom);
        end
        if (!bus.d_wr && cyc > wDoneAt && $urandom_range(0, 9) == 0) begin
          bus.d_wr = 1'b1; bus.d_wr_addr = 16'($urandom); bus.d_wr_data = 16'($urandom);
        end
      end
      if (cyc >= freeAt) begin
        if (bus.d_miss) begin
          schedFill(1'b1, bus.d_miss_addr, cyc);
          dDoneAt = cyc + 13; freeAt = cyc + 14;
        end else if (bus.d_wr) begin
          expv[cyc + 1] = '{1'b1, 1'b1, bus.d_wr_addr, bus.d_wr_data, 1'b0, 1'b0, 16'h0, 16'h0,
                            1'b0, 1'b0, 1'b1, 1'b1};
          wDoneAt = cyc + 1; freeAt = cyc + 2;
        end else if (bus.i_miss) begin
          schedFill(1'b0, bus.i_miss_addr, cyc);
          iDoneAt = cyc + 13; freeAt = cyc + 14;
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end
endmodule
